calc_sequencer: RTL
===================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 nRST  input  1  asynchronous, active-low reset.
REQ-003 read_input  input  1  key pending from keypad scanner; held high until acknowledged.
REQ-004 keypad_input  input  4  digit value 0-9; meaningful when read_input=1.
REQ-005 operator_input  input  3  operator code: 000 none, 001 negate, 010 add, 011 sub, 100 mul.
REQ-006 equal_input  input  1  equals key flag.
REQ-007 key_read  output  1  one-cycle acknowledge to keypad scanner.
REQ-008 alu_start  output  1  one-cycle ALU launch pulse.
REQ-009 alu_op  output  3  operator code for ALU; held stable from alu_start to alu_done.
REQ-010 alu_a, alu_b  output  16 each  signed two's-complement operands; held stable from alu_start to alu_done.
REQ-011 alu_done  input  1  ALU result valid pulse.
REQ-012 alu_result  input  16  signed ALU result.
REQ-013 alu_ovf  input  1  ALU overflow flag; sampled with alu_done.
REQ-014 display_value  output  16  signed value to show.
REQ-015 error  output  1  sticky error indicator.

Function
REQ-016 Key classification, priority order: equal_input=1 -> EQUALS; else operator_input!=000 -> OPERATOR; else DIGIT.
REQ-017 Key acceptance: in an entry state with read_input=1, the key is consumed and key_read pulses high for exactly one cycle.
REQ-018 After a key is consumed, no further key is consumed until read_input has been observed low (ACK_WAIT).
REQ-019 States: ENTER_A, ENTER_B, EXEC, SHOW, ERROR. Reset state is ENTER_A.
REQ-020 Operand store: 15-bit magnitude plus sign flag; presented value = sign ? -mag : mag.
REQ-021 DIGIT: mag <= mag*10 + digit.
REQ-022 DIGIT that would make mag exceed 32767 is consumed (acked) and ignored; mag is unchanged.
REQ-023 Negate (001): toggles the sign flag of the operand being entered.
REQ-024 Negate with mag=0 does not change the presented value.
REQ-025 ENTER_A + add/sub/mul: latch operand into A, latch op, clear entry, go to ENTER_B.
REQ-026 ENTER_B + add/sub/mul: see Configuration.
REQ-027 ENTER_B + EQUALS: drive alu_a=A, alu_b=B, alu_op=op; pulse alu_start one cycle; go to EXEC.
REQ-028 ENTER_A + EQUALS: no operation; key is acked.
REQ-029 EXEC: keys are not acked.
REQ-030 EXEC timeout counter (4-bit) increments each cycle; 15 cycles without alu_done -> ERROR.
REQ-031 alu_done with alu_ovf=0: display_value <= alu_result; A <= alu_result; go to SHOW.
REQ-032 alu_done with alu_ovf=1: go to ERROR.
REQ-033 SHOW + DIGIT: clear A and entry; start a new A with that digit; go to ENTER_A.
REQ-034 SHOW + add/sub/mul: keep A=result, latch op, go to ENTER_B.
REQ-035 SHOW + negate or EQUALS: acked and ignored.
REQ-036 ERROR: error=1; display_value=0; the next key of any class is acked, clears all state and goes to ENTER_A.
REQ-037 Display in entry states: display_value tracks the presented entry operand each cycle.
REQ-038 Latency: key_read asserts the cycle after read_input is first seen high in an entry state.

Reset
REQ-039 nRST low asynchronously forces: state=ENTER_A, A=B=mag=0, sign=0, op=000, key_read=0, alu_start=0, alu_op=000, alu_a=alu_b=0, display_value=0, error=0, timeout=0, ACK_WAIT cleared.
REQ-040 Reset asserted during EXEC abandons the operation; a later alu_done is ignored unless the block is in EXEC.

Configuration
REQ-041 Macro CALC_CHAIN_EN defined: ENTER_B + add/sub/mul launches the pending op as for EQUALS and records the new op; the ALU result then becomes A, the block skips SHOW and goes to ENTER_B with the new op.
REQ-042 Macro CALC_CHAIN_EN undefined: ENTER_B + add/sub/mul replaces the pending op; B is kept; no ALU launch.

Verification
REQ-043 Key sequence 1,2,add,3,EQUALS with ALU returning 15 after 2 cycles -> alu_a=12, alu_b=3, alu_op=010; display_value=15; SHOW; 5 key_read pulses.
REQ-044 Digits 3,2,7,6,7,9 -> mag stays 32767 after the sixth digit, which is acked; 7 then negate -> display_value=-7 (0xFFF9).
REQ-045 read_input held high for 20 cycles on a single key -> exactly one key_read pulse.
REQ-046 EQUALS launched with alu_done never asserted -> ERROR after 15 cycles with error=1; next key -> ENTER_A with error=0.
REQ-047 Sequence 2,add,3,sub,1,EQUALS: with CALC_CHAIN_EN defined -> the ALU computes 2+3, then 5-1, and display_value=4; with CALC_CHAIN_EN undefined -> a single ALU launch with alu_op=011 and operands A=2, B=31.
REQ-048 nRST pulsed low mid-EXEC, then alu_done -> all outputs at reset values; the late alu_done is ignored.

Source files
------------

// File: rtl/calc_sequencer_if.sv
// Keypad-scanner and ALU handshake bundle for calc_sequencer.
// master: the sequencer side; slave: keypad scanner, ALU and display side.
interface calc_sequencer_if;
  logic        read_input;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        key_read;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_ovf;
  logic [15:0] display_value;
  logic        error;

  modport master (
    input  read_input, keypad_input, operator_input, equal_input,
    input  alu_done, alu_result, alu_ovf,
    output key_read, alu_start, alu_op, alu_a, alu_b, display_value, error
  );

  modport slave (
    output read_input, keypad_input, operator_input, equal_input,
    output alu_done, alu_result, alu_ovf,
    input  key_read, alu_start, alu_op, alu_a, alu_b, display_value, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer that launches operations on an external ALU.
// Optional macro CALC_CHAIN_EN: an operator typed while entering B runs the pending op and chains.
module calc_sequencer (
  input  logic             clk,
  input  logic             nRST,
  calc_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    SHOW    = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam logic [2:0]  OP_NEG       = 3'b001;
  localparam logic [2:0]  OP_ADD       = 3'b010;
  localparam logic [2:0]  OP_SUB       = 3'b011;
  localparam logic [2:0]  OP_MUL       = 3'b100;
  localparam logic [3:0]  TIMEOUT_LAST = 4'd14;
  localparam logic [19:0] MAG_MAX      = 20'd32767;

  function automatic logic [15:0] present_value(input logic [14:0] mag, input logic sign);
    logic [15:0] ext;
    ext = {1'b0, mag};
    if (sign) begin
      present_value = 16'd0 - ext;
    end else begin
      present_value = ext;
    end
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL: is_arith = 1'b1;
      default:                is_arith = 1'b0;
    endcase
  endfunction

  state_t      state_r, state_nxt_s;
  logic        ack_wait_r, ack_wait_nxt_s;
  logic [14:0] mag_r, mag_nxt_s;
  logic        sign_r, sign_nxt_s;
  logic [15:0] a_r, a_nxt_s;
  logic [2:0]  op_r, op_nxt_s;
  logic        chain_r, chain_nxt_s;
  logic        key_read_r, key_read_nxt_s;
  logic        alu_start_r, alu_start_nxt_s;
  logic [2:0]  alu_op_r, alu_op_nxt_s;
  logic [15:0] alu_a_r, alu_a_nxt_s;
  logic [15:0] alu_b_r, alu_b_nxt_s;
  logic [15:0] display_r, display_nxt_s;
  logic        error_r, error_nxt_s;
  logic [3:0]  timeout_r, timeout_nxt_s;
  logic        accept_s;
  logic [15:0] entry_val_s;
  logic [19:0] digit_sum_s;

  // Next-state and registered-output logic for the sequencer FSM
  always_comb begin
    state_nxt_s     = state_r;
    ack_wait_nxt_s  = ack_wait_r;
    mag_nxt_s       = mag_r;
    sign_nxt_s      = sign_r;
    a_nxt_s         = a_r;
    op_nxt_s        = op_r;
    chain_nxt_s     = chain_r;
    key_read_nxt_s  = 1'b0;
    alu_start_nxt_s = 1'b0;
    alu_op_nxt_s    = alu_op_r;
    alu_a_nxt_s     = alu_a_r;
    alu_b_nxt_s     = alu_b_r;
    display_nxt_s   = display_r;
    error_nxt_s     = error_r;
    timeout_nxt_s   = timeout_r;
    entry_val_s     = present_value(mag_r, sign_r);
    digit_sum_s     = ({5'd0, mag_r} * 20'd10) + {16'd0, bus.keypad_input};
    accept_s        = bus.read_input && !ack_wait_r && (state_r != EXEC);

    // A consumed key blocks further keys until read_input has been seen low
    if (accept_s) begin
      key_read_nxt_s = 1'b1;
      ack_wait_nxt_s = 1'b1;
    end else if (!bus.read_input) begin
      ack_wait_nxt_s = 1'b0;
    end else begin
      ack_wait_nxt_s = ack_wait_r;
    end

    case (state_r)
      ENTER_A, ENTER_B: begin
        if (!accept_s) begin
          state_nxt_s = state_r;
        end else if (bus.equal_input) begin
          if (state_r == ENTER_B) begin
            alu_a_nxt_s     = a_r;
            alu_b_nxt_s     = entry_val_s;
            alu_op_nxt_s    = op_r;
            alu_start_nxt_s = 1'b1;
            timeout_nxt_s   = 4'd0;
            chain_nxt_s     = 1'b0;
            mag_nxt_s       = 15'd0;
            sign_nxt_s      = 1'b0;
            state_nxt_s     = EXEC;
          end else begin
            state_nxt_s = state_r;
          end
        end else if (bus.operator_input == OP_NEG) begin
          sign_nxt_s = ~sign_r;
        end else if (is_arith(bus.operator_input)) begin
          if (state_r == ENTER_A) begin
            a_nxt_s     = entry_val_s;
            op_nxt_s    = bus.operator_input;
            mag_nxt_s   = 15'd0;
            sign_nxt_s  = 1'b0;
            state_nxt_s = ENTER_B;
          end else begin
`ifdef CALC_CHAIN_EN
            alu_a_nxt_s     = a_r;
            alu_b_nxt_s     = entry_val_s;
            alu_op_nxt_s    = op_r;
            alu_start_nxt_s = 1'b1;
            timeout_nxt_s   = 4'd0;
            chain_nxt_s     = 1'b1;
            op_nxt_s        = bus.operator_input;
            mag_nxt_s       = 15'd0;
            sign_nxt_s      = 1'b0;
            state_nxt_s     = EXEC;
`else
            op_nxt_s = bus.operator_input;
`endif
          end
        end else if (bus.operator_input == 3'b000) begin
          // Digits that would overflow the 15-bit magnitude are swallowed
          if (digit_sum_s <= MAG_MAX) begin
            mag_nxt_s = digit_sum_s[14:0];
          end else begin
            mag_nxt_s = mag_r;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end

      EXEC: begin
        if (bus.alu_done) begin
          if (bus.alu_ovf) begin
            state_nxt_s = ERROR;
          end else begin
            a_nxt_s     = bus.alu_result;
            chain_nxt_s = 1'b0;
            if (chain_r) begin
              state_nxt_s = ENTER_B;
            end else begin
              state_nxt_s = SHOW;
            end
          end
        end else if (timeout_r == TIMEOUT_LAST) begin
          state_nxt_s = ERROR;
        end else begin
          timeout_nxt_s = timeout_r + 4'd1;
        end
      end

      SHOW: begin
        if (accept_s && !bus.equal_input && (bus.operator_input == 3'b000)) begin
          a_nxt_s     = 16'd0;
          mag_nxt_s   = {11'd0, bus.keypad_input};
          sign_nxt_s  = 1'b0;
          state_nxt_s = ENTER_A;
        end else if (accept_s && !bus.equal_input && is_arith(bus.operator_input)) begin
          op_nxt_s    = bus.operator_input;
          mag_nxt_s   = 15'd0;
          sign_nxt_s  = 1'b0;
          state_nxt_s = ENTER_B;
        end else begin
          state_nxt_s = state_r;
        end
      end

      ERROR: begin
        if (accept_s) begin
          a_nxt_s       = 16'd0;
          mag_nxt_s     = 15'd0;
          sign_nxt_s    = 1'b0;
          op_nxt_s      = 3'b000;
          chain_nxt_s   = 1'b0;
          alu_op_nxt_s  = 3'b000;
          alu_a_nxt_s   = 16'd0;
          alu_b_nxt_s   = 16'd0;
          timeout_nxt_s = 4'd0;
          state_nxt_s   = ENTER_A;
        end else begin
          state_nxt_s = state_r;
        end
      end

      default: begin
        state_nxt_s = ENTER_A;
      end
    endcase

    case (state_nxt_s)
      ENTER_A, ENTER_B: display_nxt_s = present_value(mag_nxt_s, sign_nxt_s);
      ERROR:            display_nxt_s = 16'd0;
      SHOW:             display_nxt_s = (state_r == EXEC) ? bus.alu_result : display_r;
      default:          display_nxt_s = display_r;
    endcase
    error_nxt_s = (state_nxt_s == ERROR);
  end

  // State and output registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r     <= ENTER_A;
      ack_wait_r  <= 1'b0;
      mag_r       <= 15'd0;
      sign_r      <= 1'b0;
      a_r         <= 16'd0;
      op_r        <= 3'b000;
      chain_r     <= 1'b0;
      key_read_r  <= 1'b0;
      alu_start_r <= 1'b0;
      alu_op_r    <= 3'b000;
      alu_a_r     <= 16'd0;
      alu_b_r     <= 16'd0;
      display_r   <= 16'd0;
      error_r     <= 1'b0;
      timeout_r   <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      ack_wait_r  <= ack_wait_nxt_s;
      mag_r       <= mag_nxt_s;
      sign_r      <= sign_nxt_s;
      a_r         <= a_nxt_s;
      op_r        <= op_nxt_s;
      chain_r     <= chain_nxt_s;
      key_read_r  <= key_read_nxt_s;
      alu_start_r <= alu_start_nxt_s;
      alu_op_r    <= alu_op_nxt_s;
      alu_a_r     <= alu_a_nxt_s;
      alu_b_r     <= alu_b_nxt_s;
      display_r   <= display_nxt_s;
      error_r     <= error_nxt_s;
      timeout_r   <= timeout_nxt_s;
    end
  end

  assign bus.key_read      = key_read_r;
  assign bus.alu_start     = alu_start_r;
  assign bus.alu_op        = alu_op_r;
  assign bus.alu_a         = alu_a_r;
  assign bus.alu_b         = alu_b_r;
  assign bus.display_value = display_r;
  assign bus.error         = error_r;
endmodule
